// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encodings, jump-select codes and fetch state type
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [1:0] JMP_SEQ  = 2'b00;
    localparam logic [1:0] JMP_J    = 2'b01;
    localparam logic [1:0] JMP_JR   = 2'b10;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    typedef enum logic [1:0] {FS_REQ, FS_HOLD, FS_DRAIN} fetch_state_e;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry buffer for a word returned while IF/ID is stalled
module fetch_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clr,
    input  logic [31:0] wr_instr,
    input  logic [31:0] wr_pc4,
    output logic        valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
);
    always_ff @(posedge clk) begin
        if (rst || clr) valid <= 1'b0;
        else if (push) valid <= 1'b1;
        else if (pop) valid <= 1'b0;
        if (push) begin
            instr <= wr_instr;
            pc4 <= wr_pc4;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with redirect-aware fetch FSM and skid buffer
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  jmp,
    input  logic        flush,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  func
);
    fetch_state_e state;
    logic [31:0] pc, pc_next4, target, skid_instr, skid_pc4;
    logic redirect, skid_valid, push, pop;
    assign pc_next4 = pc + 32'd4;
    assign redirect = branch_taken || (flush && (jmp == JMP_J || jmp == JMP_JR));
    assign target = branch_taken ? branch_target :
                    (flush && jmp == JMP_JR) ? jr_target :
                    {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
    assign imem_req = state == FS_REQ && !rst;
    assign imem_addr = pc;
    assign opcode = if_id_instr[31:26];
    assign func = if_id_instr[5:0];
    assign push = state == FS_REQ && imem_ack && stall && !redirect;
    assign pop = state == FS_HOLD && !stall && !redirect && skid_valid;
    fetch_skid u_skid (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .clr(redirect),
        .wr_instr(imem_rdata),
        .wr_pc4(pc_next4),
        .valid(skid_valid),
        .instr(skid_instr),
        .pc4(skid_pc4)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            state <= FS_REQ;
            if_id_instr <= NOP_WORD;
            if_id_pc4 <= '0;
            if_id_valid <= 1'b0;
        end else if (redirect) begin
            pc <= target;
            if_id_instr <= NOP_WORD;
            if_id_pc4 <= '0;
            if_id_valid <= 1'b0;
            // an unanswered request must be drained before fetching the target
            state <= (state != FS_HOLD && !imem_ack) ? FS_DRAIN : FS_REQ;
        end else begin
            case (state)
                FS_REQ:
                    if (imem_ack && !stall) begin
                        if_id_instr <= imem_rdata;
                        if_id_pc4 <= pc_next4;
                        if_id_valid <= 1'b1;
                        pc <= pc_next4;
                    end else if (imem_ack) state <= FS_HOLD;
                    else if (!stall) begin
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                    end
                FS_HOLD:
                    if (pop) begin
                        if_id_instr <= skid_instr;
                        if_id_pc4 <= skid_pc4;
                        if_id_valid <= skid_valid;
                        pc <= pc_next4;
                        state <= FS_REQ;
                    end
                FS_DRAIN: if (imem_ack) state <= FS_REQ;
                default: state <= FS_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a reference model
module tb_fetch_unit;
    import mips_pkg::*;
    logic clk = 1'b0;
    logic rst, imem_ack, stall, flush, branch_taken, imem_req, if_id_valid;
    logic [31:0] imem_rdata, jr_target, branch_target, imem_addr, if_id_instr, if_id_pc4;
    logic [1:0] jmp;
    logic [5:0] opcode, func;
    int n_chk = 0, n_pass = 0;
    int lat = 0;
    int mem_cnt = 0;
    logic mem_busy = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] m_pc, m_instr, m_pc4, m_hw, m_hp4;
    logic m_valid, m_held, m_stale;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk),
        .rst(rst),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .stall(stall),
        .jmp(jmp),
        .flush(flush),
        .jr_target(jr_target),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4),
        .if_id_valid(if_id_valid),
        .opcode(opcode),
        .func(func)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a == 32'h0 ? 32'h2008_0005 :
               a == 32'h4 ? 32'h3C01_0001 :
               a == 32'h20 ? 32'h0800_0010 :
               ((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clr_in();
        stall = 1'b0;
        flush = 1'b0;
        jmp = 2'b00;
        branch_taken = 1'b0;
    endtask

    // memory: one request at a time, answered after lat cycles; stray acks when idle
    task automatic mem_drive();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        if (rst) begin
            mem_busy = 1'b0;
            imem_ack = $urandom_range(3) == 0;
            return;
        end
        if (!mem_busy && imem_req) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt = lat < 0 ? int'($urandom_range(2)) : lat;
        end
        if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_ack = 1'b1;
                imem_rdata = word(mem_addr);
                mem_busy = 1'b0;
            end else mem_cnt--;
        end else if (!imem_req && $urandom_range(7) == 0) imem_ack = 1'b1;
    endtask

    task automatic model_step();
        logic red, fetching;
        logic [31:0] tgt;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
            m_valid = 1'b0; m_held = 1'b0; m_stale = 1'b0;
            return;
        end
        red = branch_taken || (flush && (jmp == 2'b01 || jmp == 2'b10));
        tgt = branch_taken ? branch_target :
              (flush && jmp == 2'b10) ? jr_target : {m_pc4[31:28], m_instr[25:0], 2'b00};
        fetching = !m_held && !m_stale;
        if (red) begin
            m_stale = (fetching || m_stale) && !imem_ack;
            m_held = 1'b0;
            m_pc = tgt; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (m_stale) m_stale = !imem_ack;
        else if (m_held) begin
            if (!stall) begin
                m_instr = m_hw; m_pc4 = m_hp4; m_valid = 1'b1;
                m_held = 1'b0; m_pc = m_pc + 32'd4;
            end
        end else if (imem_ack && stall) begin
            m_held = 1'b1; m_hw = imem_rdata; m_hp4 = m_pc + 32'd4;
        end else if (imem_ack) begin
            m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end else if (!stall) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end
    endtask

    task automatic check_all();
        logic er;
        er = !rst && !m_held && !m_stale;
        chk("imem_req", imem_req, er);
        if (er) chk("imem_addr", imem_addr, m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc4", if_id_pc4, m_pc4);
        chk("if_id_valid", if_id_valid, m_valid);
        chk("opcode", opcode, m_instr[31:26]);
        chk("func", func, m_instr[5:0]);
    endtask

    task automatic step();
        mem_drive();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        branch_target = '0;
        jr_target = '0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        lat = 0;
        repeat (3) step();
        chk("rst_req", imem_req, 0);
        chk("rst_valid", if_id_valid, 0);
        rst = 1'b0;
        #1;
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, 32'h0);
        step();
        chk("w0_pc4", if_id_pc4, 32'h4);
        chk("w0_op", opcode, 6'h08);
        chk("w0_addr", imem_addr, 32'h4);
        step();
        chk("w1_pc4", if_id_pc4, 32'h8);
        chk("w1_op", opcode, 6'h0F);
        stall = 1'b1;
        repeat (3) begin
            step();
            chk("stall_req", imem_req, 0);
            chk("stall_pc4", if_id_pc4, 32'h8);
        end
        stall = 1'b0;
        step();
        chk("unstall_instr", if_id_instr, word(32'h8));
        chk("unstall_pc4", if_id_pc4, 32'hC);
        chk("unstall_addr", imem_addr, 32'hC);
        branch_taken = 1'b1;
        branch_target = 32'h20;
        step();
        clr_in();
        chk("br_valid", if_id_valid, 0);
        chk("br_addr", imem_addr, 32'h20);
        step();
        chk("j_src_instr", if_id_instr, 32'h0800_0010);
        chk("j_src_pc4", if_id_pc4, 32'h24);
        flush = 1'b1;
        jmp = 2'b01;
        step();
        clr_in();
        chk("j_addr", imem_addr, 32'h40);
        chk("j_valid", if_id_valid, 0);
        branch_taken = 1'b1;
        branch_target = 32'h100;
        flush = 1'b1;
        jmp = 2'b10;
        jr_target = 32'h200;
        step();
        clr_in();
        chk("prio_addr", imem_addr, 32'h100);
        lat = 2;
        step();
        branch_taken = 1'b1;
        branch_target = 32'h300;
        step();
        clr_in();
        chk("drain_req", imem_req, 0);
        step();
        chk("drain_done_req", imem_req, 1);
        chk("drain_addr", imem_addr, 32'h300);
        chk("drain_valid", if_id_valid, 0);
        repeat (2) begin
            step();
            chk("drain_wait_valid", if_id_valid, 0);
        end
        step();
        chk("drain_new_instr", if_id_instr, word(32'h300));
        chk("drain_new_valid", if_id_valid, 1);
        lat = 0;
        stall = 1'b1;
        step();
        rst = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h500;
        step();
        clr_in();
        chk("hold_rst_req", imem_req, 0);
        chk("hold_rst_instr", if_id_instr, 32'h0);
        chk("hold_rst_pc4", if_id_pc4, 32'h0);
        chk("hold_rst_valid", if_id_valid, 0);
        rst = 1'b0;
        #1;
        chk("hold_rst_boot_req", imem_req, 1);
        chk("hold_rst_boot_addr", imem_addr, 32'h0);
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        step();
        clr_in();
        step();
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        lat = -1;
        repeat (3000) begin
            rst = $urandom_range(199) == 0;
            stall = $urandom_range(3) == 0;
            branch_taken = $urandom_range(15) == 0;
            flush = $urandom_range(7) == 0;
            jmp = 2'($urandom);
            branch_target = $urandom & 32'hFFFF_FFFC;
            jr_target = $urandom & 32'hFFFF_FFFC;
            step();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  fetch address, word aligned
- imem_ack  in  1  response valid; imem_rdata sampled this cycle
- imem_rdata  in  32  instruction word
- stall  in  1  hazard unit: hold IF/ID
- jmp  in  2  00 sequential, 01 j/jal, 10 jr/jalr, 11 treated as 00
- flush  in  1  from controller, qualifies jmp
- jr_target  in  32  rs value for jr/jalr
- branch_taken  in  1  beq/bne resolved taken
- branch_target  in  32  branch destination
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction
- opcode  out  6  if_id_instr[31:26], to controller
- func  out  6  if_id_instr[5:0], to controller

Function
REQ-004 States SHALL be REQ (request outstanding), HOLD (word buffered, stalled), and DRAIN (discarding a stale in-flight response).
REQ-005 In REQ, imem_req SHALL be 1; imem_addr SHALL equal pc and stay stable until imem_ack.
REQ-006 On imem_ack in REQ with no stall and no redirect, the block SHALL load IF/ID with {imem_rdata, pc+4, valid=1}, set pc<=pc+4, and stay in REQ.
REQ-007 On imem_ack in REQ with stall=1 and no redirect, the block SHALL store the word and pc+4 in the skid buffer, hold IF/ID, drop imem_req, and enter HOLD.
REQ-008 In HOLD, on stall=0 the block SHALL move the skid entry into IF/ID, set pc<=pc+4, and return to REQ next cycle.
REQ-009 A redirect SHALL be branch_taken, or flush=1 with jmp=01 or jmp=10.
REQ-010 Redirect priority SHALL be branch_taken > jmp=10 > jmp=01.
REQ-011 Targets: branch -> branch_target; jr -> jr_target; j -> {if_id_pc4[31:28], if_id_instr[25:0], 2'b00}.
REQ-012 On a redirect, the block SHALL set pc<=target and IF/ID<={32'h0 (NOP), target? no: 32'h0, valid=0}, and invalidate the skid buffer; redirect SHALL override stall.
REQ-013 If a redirect occurs in REQ without imem_ack the same cycle, the block SHALL enter DRAIN; imem_req SHALL be 0 in DRAIN.
REQ-014 In DRAIN, the block SHALL discard the word on imem_ack and enter REQ at the redirected pc.
REQ-015 An imem_ack arriving in the same cycle as a redirect SHALL be discarded, and the block SHALL enter REQ.
REQ-016 A second redirect during DRAIN SHALL update pc only and keep the state DRAIN.
REQ-017 opcode and func SHALL be combinational slices of if_id_instr.
REQ-018 imem_ack outside REQ/DRAIN SHALL be ignored.
REQ-019 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 0.

Reset
REQ-020 While rst=1, the block SHALL set pc=RESET_PC, state=REQ, IF/ID instr=0, pc4=0, valid=0, skid invalid, and imem_req=0.
REQ-021 On the first cycle after rst falls, the block SHALL drive imem_req=1 at RESET_PC; a response in flight at reset SHALL be lost and not retried.

Structure
REQ-022 The shared package mips_pkg SHALL hold the opcode/func constants, JMP_SEQ/JMP_J/JMP_JR encodings, NOP_WORD=32'h0, and the fetch state enum.
REQ-023 The 1-entry skid buffer SHALL be a sub-module named fetch_skid; the pc mux and FSM SHALL be inline.

Verification
REQ-024 Reset with ack every cycle, words 0x20080005 and 0x3C010001 -> addr 0x0, then 0x4; IF/ID pc4=0x4, then 0x8; opcode=0x08, then 0x0F.
REQ-025 stall=1 for 3 cycles during an ack -> IF/ID unchanged 3 cycles, imem_req=0, no word lost, next addr=pc+4.
REQ-026 IF/ID=0x08000010, pc4=0x0000_0024, flush=1, jmp=01 -> next addr 0x40, valid=0.
REQ-027 branch_taken=1 (target 0x100) with flush=1, jmp=10 (jr_target 0x200) in the same cycle -> next addr 0x100.
REQ-028 Redirect while ack is delayed 2 cycles -> DRAIN; stale word discarded; next request at target; valid=0 until the new ack.
REQ-029 rst during HOLD with a pending redirect -> all outputs at reset values; first request at RESET_PC.
